pmp_checker: RTL and testbench

// - Multi-entry RISC-V PMP access checker. Generalises the single-entry TOR matcher to N entries and all

---
 rtl/pmp_pkg.sv | 36 +++
 rtl/pmp_entry_match.sv | 74 +++++++
 rtl/pmp_checker.sv | 186 ++++++++++++++++++
 tb/tb_pmp_checker.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmp_pkg.sv
// Shared types for the PMP checker: entry address modes, cfg byte layout,
// access kinds and the scan FSM states.
// Purely declarative; no logic.
package pmp_pkg;

  typedef enum logic [1:0] {
    PMP_OFF   = 2'b00,
    PMP_TOR   = 2'b01,
    PMP_NA4   = 2'b10,
    PMP_NAPOT = 2'b11
  } pmp_mode_e;

  // One pmpcfg byte: {L, 2'b0, A[1:0], X, W, R}
  typedef struct packed {
    logic      l;
    logic [1:0] rsvd;
    pmp_mode_e a;
    logic      x;
    logic      w;
    logic      r;
  } pmp_cfg_t;

  // Encoding 2'b11 is reserved and rejected at accept.
  typedef enum logic [1:0] {
    ACC_READ  = 2'b00,
    ACC_WRITE = 2'b01,
    ACC_EXEC  = 2'b10
  } pmp_acc_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_RESP = 2'b10
  } pmp_state_e;

endpackage

// File: rtl/pmp_entry_match.sv
// Purpose: classify an access span [i_addr, i_end] against one PMP entry region.
// Latency: combinational. Backpressure: none.
// Ports: i_addr/i_end access span (i_end is one bit wider to expose carry past the
//   top of the address space), i_cfg entry cfg byte, i_pmpaddr / i_pmpaddr_prev this
//   and the previous entry's pmpaddr; o_full all bytes inside, o_partial some bytes inside.
module pmp_entry_match
  import pmp_pkg::*;
#(
  parameter int PA_W = 34
) (
  input  logic [PA_W-1:0] i_addr,
  input  logic [PA_W:0]   i_end,
  input  logic [7:0]      i_cfg,
  input  logic [PA_W-3:0] i_pmpaddr,
  input  logic [PA_W-3:0] i_pmpaddr_prev,
  output logic            o_full,
  output logic            o_partial
);

  localparam int AW = PA_W - 2;
  localparam int EW = PA_W + 1;

  pmp_cfg_t      w_cfg;
  logic [AW-1:0] w_napot_mask;
  logic [EW-1:0] w_lo;
  logic [EW-1:0] w_hi;
  logic [EW-1:0] w_addr;
  logic          w_en;
  logic          w_overlap;
  logic          w_unused;

  assign w_cfg    = pmp_cfg_t'(i_cfg);
  assign w_unused = ^{w_cfg.l, w_cfg.rsvd, w_cfg.x, w_cfg.w, w_cfg.r};

  // Region is the half-open byte range [w_lo, w_hi) held in PA_W+1 bits so that a
  // region ending at the very top of the address space can be represented.
  always_comb begin
    // x ^ (x+1) sets bits 0..t where t is the count of trailing ones; for an
    // all-ones pmpaddr the increment wraps and the mask becomes all ones.
    w_napot_mask = i_pmpaddr ^ (i_pmpaddr + AW'(1));
    w_lo = '0;
    w_hi = '0;
    w_en = 1'b0;
    case (w_cfg.a)
      PMP_TOR: begin
        w_lo = {1'b0, i_pmpaddr_prev, 2'b00};
        w_hi = {1'b0, i_pmpaddr, 2'b00};
        w_en = 1'b1;
      end
      PMP_NA4: begin
        w_lo = {1'b0, i_pmpaddr, 2'b00};
        w_hi = {1'b0, i_pmpaddr, 2'b00} + EW'(4);
        w_en = 1'b1;
      end
      PMP_NAPOT: begin
        w_lo = {1'b0, i_pmpaddr & ~w_napot_mask, 2'b00};
        w_hi = {1'b0, i_pmpaddr | w_napot_mask, 2'b11} + EW'(1);
        w_en = 1'b1;
      end
      default: begin
        w_en = 1'b0;
      end
    endcase
  end

  assign w_addr = {1'b0, i_addr};

  // A span that carried past the top has i_end >= w_hi, so it can never be a full
  // match; any overlap with it therefore lands in the partial (deny) class.
  assign o_full    = w_en && (w_lo <= w_addr) && (i_end < w_hi);
  assign w_overlap = w_en && (w_lo < w_hi) && (w_lo <= i_end) && (w_addr < w_hi);
  assign o_partial = w_overlap && !o_full;

endmodule

// File: rtl/pmp_checker.sv
// Purpose: multi-entry RISC-V PMP checker scanning one entry per cycle (lowest index wins).
// Latency: rsp_valid after edge i+1 when entry i decides, else after edge N_ENTRIES.
// Backpressure: one request in flight; req_ready only in IDLE, response held until rsp_ready.
// Ports: req_* access request (valid/ready); pmpcfg_i/pmpaddr_i packed entry tables that
//   must stay stable while busy; rsp_* decision (valid/ready); busy high in SCAN or RESP.
module pmp_checker
  import pmp_pkg::*;
#(
  parameter int N_ENTRIES = 16,
  parameter int PA_W      = 34,
  localparam int IDX_W    = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [PA_W-1:0]               req_addr,
  input  logic [1:0]                    req_size,
  input  logic [1:0]                    req_acc,
  input  logic                          req_priv_m,
  input  logic [8*N_ENTRIES-1:0]        pmpcfg_i,
  input  logic [(PA_W-2)*N_ENTRIES-1:0] pmpaddr_i,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_allow,
  output logic                          rsp_hit,
  output logic [IDX_W-1:0]              rsp_idx,
  output logic                          busy
);

  localparam int AW = PA_W - 2;
  localparam int EW = PA_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);

  pmp_state_e       r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [PA_W-1:0]  r_addr;
  logic [EW-1:0]    r_end;
  logic [1:0]       r_acc;
  logic             r_priv_m;
  logic             r_bad;
  logic             r_rsp_allow, w_rsp_allow_nxt;
  logic             r_rsp_hit, w_rsp_hit_nxt;
  logic [IDX_W-1:0] r_rsp_idx, w_rsp_idx_nxt;

  logic             w_accept;
  logic [EW-1:0]    w_req_end;
  logic [7:0]       w_cfg;
  pmp_cfg_t         w_cfg_s;
  logic [AW-1:0]    w_pmpaddr;
  logic [AW-1:0]    w_pmpaddr_prev;
  logic             w_full;
  logic             w_partial;
  logic             w_perm;
  logic             w_allow_dec;
  logic             w_unused;

  assign w_accept  = req_valid && (r_state == ST_IDLE);
  assign w_req_end = {1'b0, req_addr} + (EW'(1) << req_size) - EW'(1);

  // Select the entry under scan.
  always_comb begin
    w_cfg          = pmpcfg_i[8*int'(r_idx) +: 8];
    w_pmpaddr      = pmpaddr_i[AW*int'(r_idx) +: AW];
    w_pmpaddr_prev = '0;
    if (r_idx != '0) begin
      w_pmpaddr_prev = pmpaddr_i[AW*(int'(r_idx)-1) +: AW];
    end
  end

  assign w_cfg_s  = pmp_cfg_t'(w_cfg);
  assign w_unused = ^w_cfg_s.rsvd;

  pmp_entry_match #(
    .PA_W(PA_W)
  ) u_match (
    .i_addr        (r_addr),
    .i_end         (r_end),
    .i_cfg         (w_cfg),
    .i_pmpaddr     (w_pmpaddr),
    .i_pmpaddr_prev(w_pmpaddr_prev),
    .o_full        (w_full),
    .o_partial     (w_partial)
  );

  always_comb begin
    w_perm = 1'b0;
    case (r_acc)
      ACC_READ:  w_perm = w_cfg_s.r;
      ACC_WRITE: w_perm = w_cfg_s.w;
      ACC_EXEC:  w_perm = w_cfg_s.x;
      default:   w_perm = 1'b0;
    endcase
    // Unlocked entries do not constrain M-mode; partial matches always deny.
    if (w_partial) begin
      w_allow_dec = 1'b0;
    end else if (r_priv_m && !w_cfg_s.l) begin
      w_allow_dec = 1'b1;
    end else begin
      w_allow_dec = w_perm;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_rsp_allow_nxt = r_rsp_allow;
    w_rsp_hit_nxt   = r_rsp_hit;
    w_rsp_idx_nxt   = r_rsp_idx;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_state_nxt = ST_SCAN;
          w_idx_nxt   = '0;
        end
      end
      ST_SCAN: begin
        // Reserved size/access skips the table but takes the same single cycle
        // as an entry-0 decision.
        if (r_bad) begin
          w_state_nxt     = ST_RESP;
          w_rsp_allow_nxt = 1'b0;
          w_rsp_hit_nxt   = 1'b0;
          w_rsp_idx_nxt   = '0;
        end else if (w_full || w_partial) begin
          w_state_nxt     = ST_RESP;
          w_rsp_allow_nxt = w_allow_dec;
          w_rsp_hit_nxt   = 1'b1;
          w_rsp_idx_nxt   = r_idx;
        end else if (r_idx == LAST_IDX) begin
          w_state_nxt     = ST_RESP;
          w_rsp_allow_nxt = r_priv_m;
          w_rsp_hit_nxt   = 1'b0;
          w_rsp_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // rst_n is expected to be release-synchronised upstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_addr      <= '0;
      r_end       <= '0;
      r_acc       <= '0;
      r_priv_m    <= 1'b0;
      r_bad       <= 1'b0;
      r_rsp_allow <= 1'b0;
      r_rsp_hit   <= 1'b0;
      r_rsp_idx   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_rsp_allow <= w_rsp_allow_nxt;
      r_rsp_hit   <= w_rsp_hit_nxt;
      r_rsp_idx   <= w_rsp_idx_nxt;
      if (w_accept) begin
        r_addr   <= req_addr;
        r_end    <= w_req_end;
        r_acc    <= req_acc;
        r_priv_m <= req_priv_m;
        r_bad    <= (req_size == 2'b11) || (req_acc == 2'b11);
      end
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);
  assign busy      = (r_state != ST_IDLE);
  assign rsp_allow = r_rsp_allow;
  assign rsp_hit   = r_rsp_hit;
  assign rsp_idx   = r_rsp_idx;

endmodule

// File: tb/tb_pmp_checker.sv
// Directed bench for pmp_checker: a byte-level reference model predicts each
// response and its latency; a per-cycle compare process checks the handshake
// and response fields, and each vector also pins the model to hand values.
module tb_pmp_checker;

  localparam int N     = 16;
  localparam int PA_W  = 34;
  localparam int AW    = PA_W - 2;
  localparam int IDX_W = 4;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [PA_W-1:0]  req_addr;
  logic [1:0]       req_size;
  logic [1:0]       req_acc;
  logic             req_priv_m;
  logic [8*N-1:0]   pmpcfg;
  logic [AW*N-1:0]  pmpaddr;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_allow;
  logic             rsp_hit;
  logic [IDX_W-1:0] rsp_idx;
  logic             busy;

  logic [7:0]    cfg   [N];
  logic [AW-1:0] paddr [N];

  int   checks   = 0;
  int   failures = 0;
  logic tx_active = 1'b0;
  int   edge_cnt  = 0;
  logic exp_allow;
  logic exp_hit;
  int   exp_idx;
  int   exp_lat;
  logic exp_v;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign pmpcfg[8*g +: 8]    = cfg[g];
    assign pmpaddr[AW*g +: AW] = paddr[g];
  end

  pmp_checker #(.N_ENTRIES(N), .PA_W(PA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_acc   (req_acc),
    .req_priv_m(req_priv_m),
    .pmpcfg_i  (pmpcfg),
    .pmpaddr_i (pmpaddr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_allow (rsp_allow),
    .rsp_hit   (rsp_hit),
    .rsp_idx   (rsp_idx),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: walk entries in order, count how many bytes of the access fall in
  // each entry's region. Bytes beyond the top of the address space belong to no region.
  function automatic void model(input logic [PA_W-1:0] a, input logic [1:0] sz,
                                input logic [1:0] acc, input logic pm,
                                output logic allow, output logic hit,
                                output int idx, output int lat);
    longint lo, hi, nb, b, cnt;
    int     t;
    allow = pm; hit = 1'b0; idx = 0; lat = N;
    if (sz == 2'b11 || acc == 2'b11) begin
      allow = 1'b0; lat = 1;
      return;
    end
    nb = longint'(1) << sz;
    for (int i = 0; i < N; i++) begin
      lo = 0; hi = 0;
      case (cfg[i][4:3])
        2'b01: begin
          lo = (i == 0) ? 0 : longint'(paddr[i-1]) * 4;
          hi = longint'(paddr[i]) * 4;
        end
        2'b10: begin
          lo = longint'(paddr[i]) * 4;
          hi = lo + 4;
        end
        2'b11: begin
          t = 0;
          while (t < AW && paddr[i][t]) t++;
          if (t == AW) begin
            lo = 0;
            hi = longint'(1) << PA_W;
          end else begin
            lo = (longint'(paddr[i]) >> t << t) * 4;
            hi = lo + (longint'(1) << (t + 3));
          end
        end
        default: ;
      endcase
      if (cfg[i][4:3] != 2'b00) begin
        cnt = 0;
        for (longint k = 0; k < nb; k++) begin
          b = longint'(a) + k;
          if (b < (longint'(1) << PA_W) && b >= lo && b < hi) cnt++;
        end
        if (cnt > 0) begin
          hit = 1'b1; idx = i; lat = i + 1;
          if (cnt < nb)                 allow = 1'b0;
          else if (pm && !cfg[i][7])    allow = 1'b1;
          else if (acc == 2'b00)        allow = cfg[i][0];
          else if (acc == 2'b01)        allow = cfg[i][1];
          else                          allow = cfg[i][2];
          return;
        end
      end
    end
  endfunction

  // Edges since the accepting edge of the transaction in flight.
  always @(posedge clk) edge_cnt <= tx_active ? edge_cnt + 1 : 0;

  // Per-cycle comparison against the model's prediction.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_active) begin
        exp_v = (edge_cnt >= exp_lat);
        chk("cyc_rsp_valid", rsp_valid, exp_v);
        chk("cyc_req_ready", req_ready, 1'b0);
        chk("cyc_busy", busy, 1'b1);
        if (exp_v) begin
          chk("cyc_rsp_allow", rsp_allow, exp_allow);
          chk("cyc_rsp_hit", rsp_hit, exp_hit);
          chk("cyc_rsp_idx", rsp_idx, exp_idx);
        end
      end else begin
        chk("idle_rsp_valid", rsp_valid, 1'b0);
        chk("idle_req_ready", req_ready, 1'b1);
        chk("idle_busy", busy, 1'b0);
      end
    end
  end

  task automatic clear_entries();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      cfg[i]   = 8'h00;
      paddr[i] = '0;
    end
  endtask

  task automatic issue(input string nm, input logic [PA_W-1:0] a, input logic [1:0] sz,
                       input logic [1:0] acc, input logic pm,
                       input int e_allow, input int e_hit, input int e_idx, input int e_lat);
    logic m_a, m_h;
    int   m_i, m_l;
    model(a, sz, acc, pm, m_a, m_h, m_i, m_l);
    chk({nm, "_model_allow"}, m_a, e_allow);
    chk({nm, "_model_hit"}, m_h, e_hit);
    chk({nm, "_model_idx"}, m_i, e_idx);
    chk({nm, "_model_lat"}, m_l, e_lat);
    exp_allow = m_a; exp_hit = m_h; exp_idx = m_i; exp_lat = m_l;
    @(negedge clk);
    req_addr = a; req_size = sz; req_acc = acc; req_priv_m = pm;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    tx_active = 1'b1;
  endtask

  task automatic finish_tx(input string nm, input int stall);
    int n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) chk({nm, "_rsp_timeout"}, 0, 1);
    repeat (stall) @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    tx_active = 1'b0;
  endtask

  task automatic run(input string nm, input logic [PA_W-1:0] a, input logic [1:0] sz,
                     input logic [1:0] acc, input logic pm,
                     input int e_allow, input int e_hit, input int e_idx, input int e_lat,
                     input int stall);
    issue(nm, a, sz, acc, pm, e_allow, e_hit, e_idx, e_lat);
    finish_tx(nm, stall);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_addr = '0; req_size = '0; req_acc = '0; req_priv_m = 1'b0;
    for (int i = 0; i < N; i++) begin
      cfg[i] = 8'h00; paddr[i] = '0;
    end
    #1 rst_n = 1'b0;
    #2;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_allow", rsp_allow, 1'b0);
    chk("rst_rsp_hit", rsp_hit, 1'b0);
    chk("rst_rsp_idx", rsp_idx, 0);
    chk("rst_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // All entries OFF
    run("off_m",  34'h1000, 2'd2, 2'd0, 1'b1, 1, 0, 0, 16, 0);
    run("off_u",  34'h1000, 2'd2, 2'd0, 1'b0, 0, 0, 0, 16, 0);

    // TOR entry 0 up to 0x1000, read only
    clear_entries();
    cfg[0] = 8'h09; paddr[0] = 32'h400;
    run("tor_rd_stall", 34'h0FFC, 2'd2, 2'd0, 1'b0, 1, 1, 0, 1, 5);
    run("tor_wr",       34'h0FFC, 2'd2, 2'd1, 1'b0, 0, 1, 0, 1, 0);
    run("tor_partial",  34'h0FFE, 2'd2, 2'd0, 1'b0, 0, 1, 0, 1, 0);
    run("lock0_m_wr",   34'h0010, 2'd2, 2'd1, 1'b1, 1, 1, 0, 1, 0);
    run("bad_size",     34'h0010, 2'd3, 2'd0, 1'b1, 0, 0, 0, 1, 0);
    run("bad_acc",      34'h0010, 2'd2, 2'd3, 1'b1, 0, 0, 0, 1, 0);
    @(negedge clk); cfg[0] = 8'h89;
    run("lock1_m_wr",   34'h0010, 2'd2, 2'd1, 1'b1, 0, 1, 0, 1, 0);

    // NAPOT entry 3: 0x1000-0x1FFF, exec only
    clear_entries();
    cfg[3] = 8'h1C; paddr[3] = 32'h5FF;
    run("napot_x",  34'h1800, 2'd0, 2'd2, 1'b0, 1, 1, 3, 4, 0);
    run("napot_r",  34'h1800, 2'd0, 2'd0, 1'b0, 0, 1, 3, 4, 0);
    run("napot_mr", 34'h1800, 2'd0, 2'd0, 1'b1, 1, 1, 3, 4, 0);

    // Priority: NA4 no-perm entry 1 shadows NAPOT R entry 2 (0x2000-0x3FFF)
    clear_entries();
    cfg[1] = 8'h10; paddr[1] = 32'h800;
    cfg[2] = 8'h19; paddr[2] = 32'hBFF;
    run("prio_na4",  34'h2000, 2'd2, 2'd0, 1'b0, 0, 1, 1, 2, 0);
    run("prio_next", 34'h2004, 2'd2, 2'd0, 1'b0, 1, 1, 2, 3, 0);
    run("na4_part",  34'h1FFE, 2'd2, 2'd0, 1'b0, 0, 1, 1, 2, 0);

    // Whole-space NAPOT and wrap past the top
    clear_entries();
    cfg[0] = 8'h19; paddr[0] = 32'hFFFF_FFFF;
    run("all_top_byte", 34'h3_FFFF_FFFF, 2'd0, 2'd0, 1'b0, 1, 1, 0, 1, 0);
    run("all_wrap",     34'h3_FFFF_FFFE, 2'd2, 2'd0, 1'b0, 0, 1, 0, 1, 0);

    // Empty TOR (lo >= hi) is skipped; following TOR decides
    clear_entries();
    paddr[0] = 32'h800; cfg[1] = 8'h0B; paddr[1] = 32'h400;
    cfg[2] = 8'h0B; paddr[2] = 32'h800;
    run("tor_empty", 34'h1000, 2'd2, 2'd0, 1'b0, 1, 1, 2, 3, 0);

    // Wrap with no entries: M-mode default
    clear_entries();
    run("wrap_none_m", 34'h3_FFFF_FFFF, 2'd1, 2'd0, 1'b1, 1, 0, 0, 16, 0);

    // Reset in the middle of a scan
    issue("rst_scan", 34'h1000, 2'd2, 2'd0, 1'b1, 1, 0, 0, 16);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    tx_active = 1'b0;
    #1;
    chk("rst_scan_rsp_valid", rsp_valid, 1'b0);
    chk("rst_scan_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_req_ready", req_ready, 1'b1);
    run("post_rst", 34'h1000, 2'd2, 2'd0, 1'b1, 1, 0, 0, 16, 0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
